mic_volume_ctrl: RTL and testbench



---
 rtl/mic_pkg.sv | 24 ++
 rtl/mic_peak_window.sv | 85 ++++++++
 rtl/mic_volume_ctrl.sv | 154 +++++++++++++++
 tb/tb_mic_volume_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mic_pkg.sv
// Shared constants and types for the microphone volume path and the bar-meter renderer.
package mic_pkg;

    localparam int unsigned SAMPLE_W      = 12;
    localparam int unsigned LEVEL_W       = 5;
    localparam int unsigned THEME_W       = 2;
    localparam int unsigned HOLD_W        = 4;
    localparam int unsigned COUNT_W       = 16;

    localparam int unsigned MIC_MIDPOINT  = 2048;
    localparam int unsigned MIC_MAX_LEVEL = 15;
    localparam int unsigned AMP_MAX       = 2047;

    // Renderer colour-band thresholds on the committed volume level.
    localparam logic [LEVEL_W-1:0] THRESH_GREEN  = 5'd5;
    localparam logic [LEVEL_W-1:0] THRESH_YELLOW = 5'd10;
    localparam logic [LEVEL_W-1:0] THRESH_RED    = 5'd13;

    typedef enum logic {
        HOLD  = 1'b0,
        DECAY = 1'b1
    } peak_state_e;

endpackage

// File: rtl/mic_peak_window.sv
// Windowed peak detector: rectifies each valid sample around the ADC midpoint and
// reports the saturated level of the window peak on the sample that closes the window.
module mic_peak_window
    import mic_pkg::*;
#(
    parameter int WINDOW_SAMPLES = 1000,
    parameter int MIDPOINT       = 2048,
    parameter int LEVEL_SHIFT    = 6,
    parameter int MAX_LEVEL      = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample,
    output logic                window_end,
    output logic [LEVEL_W-1:0]  raw
);

    localparam logic [SAMPLE_W-1:0] MID_CODE   = SAMPLE_W'(MIDPOINT);
    localparam logic [SAMPLE_W-1:0] AMP_SAT    = SAMPLE_W'(AMP_MAX);
    localparam logic [SAMPLE_W-1:0] LEVEL_SAT  = SAMPLE_W'(MAX_LEVEL);
    localparam logic [COUNT_W-1:0]  LAST_COUNT = COUNT_W'(WINDOW_SAMPLES - 1);

    logic [SAMPLE_W-1:0] diff_s;
    logic [SAMPLE_W-1:0] amp_s;
    logic [SAMPLE_W-1:0] peak_next_s;
    logic [SAMPLE_W-1:0] shifted_s;
    logic [SAMPLE_W-1:0] peak_r;
    logic [COUNT_W-1:0]  count_r;

    // Rectified amplitude, running max including the current sample, and window level.
    always_comb begin
        diff_s      = {SAMPLE_W{1'b0}};
        amp_s       = {SAMPLE_W{1'b0}};
        peak_next_s = peak_r;
        shifted_s   = {SAMPLE_W{1'b0}};
        raw         = {LEVEL_W{1'b0}};

        if (sample >= MID_CODE) begin
            diff_s = sample - MID_CODE;
        end else begin
            diff_s = MID_CODE - sample;
        end

        // The negative half has one more code than the positive half; clip it.
        if (diff_s > AMP_SAT) begin
            amp_s = AMP_SAT;
        end else begin
            amp_s = diff_s;
        end

        if (amp_s > peak_r) begin
            peak_next_s = amp_s;
        end else begin
            peak_next_s = peak_r;
        end

        shifted_s = peak_next_s >> LEVEL_SHIFT;
        if (shifted_s > LEVEL_SAT) begin
            raw = LEVEL_SAT[LEVEL_W-1:0];
        end else begin
            raw = shifted_s[LEVEL_W-1:0];
        end
    end

    assign window_end = sample_valid && (count_r == LAST_COUNT);

    // Peak and sample-count accumulation; both restart after the closing sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            peak_r  <= {SAMPLE_W{1'b0}};
            count_r <= {COUNT_W{1'b0}};
        end else if (window_end) begin
            peak_r  <= {SAMPLE_W{1'b0}};
            count_r <= {COUNT_W{1'b0}};
        end else if (sample_valid) begin
            peak_r  <= peak_next_s;
            count_r <= count_r + {{(COUNT_W-1){1'b0}}, 1'b1};
        end else begin
            peak_r  <= peak_r;
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/mic_volume_ctrl.sv
// Microphone volume controller: peak-hold with stepwise decay on windowed levels, plus a
// theme counter, with volume and theme committed to the renderer only at frame start.
module mic_volume_ctrl
    import mic_pkg::*;
#(
    parameter int WINDOW_SAMPLES = 1000,
    parameter int HOLD_WINDOWS   = 4,
    parameter int MIDPOINT       = MIC_MIDPOINT,
    parameter int LEVEL_SHIFT    = 6,
    parameter int MAX_LEVEL      = MIC_MAX_LEVEL
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic                frame_begin,
    input  logic                theme_btn,
    input  logic                freeze,
    output logic [LEVEL_W-1:0]  volume,
    output logic [THEME_W-1:0]  theme_sw,
    output logic                volume_upd
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_WINDOWS - 1);

    logic                window_end_s;
    logic [LEVEL_W-1:0]  raw_s;

    peak_state_e         state_r;
    peak_state_e         state_next_s;
    logic [LEVEL_W-1:0]  level_r;
    logic [LEVEL_W-1:0]  level_next_s;
    logic [HOLD_W-1:0]   hold_cnt_r;
    logic [HOLD_W-1:0]   hold_next_s;
    logic [HOLD_W-1:0]   hold_inc_s;
    logic [THEME_W-1:0]  pending_theme_r;
    logic [LEVEL_W-1:0]  volume_r;
    logic [THEME_W-1:0]  theme_r;
    logic                volume_upd_r;

    mic_peak_window #(
        .WINDOW_SAMPLES (WINDOW_SAMPLES),
        .MIDPOINT       (MIDPOINT),
        .LEVEL_SHIFT    (LEVEL_SHIFT),
        .MAX_LEVEL      (MAX_LEVEL)
    ) u_peak_window (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample       (sample),
        .window_end   (window_end_s),
        .raw          (raw_s)
    );

    // Peak-hold / decay next-state logic, evaluated once per completed window.
    always_comb begin
        state_next_s = state_r;
        level_next_s = level_r;
        hold_next_s  = hold_cnt_r;
        hold_inc_s   = hold_cnt_r + 4'd1;

        if (window_end_s) begin
            case (state_r)
                HOLD: begin
                    if (raw_s >= level_r) begin
                        level_next_s = raw_s;
                        hold_next_s  = 4'd0;
                        state_next_s = HOLD;
                    end else if (hold_inc_s >= HOLD_LAST) begin
                        hold_next_s  = hold_inc_s;
                        state_next_s = DECAY;
                    end else begin
                        hold_next_s  = hold_inc_s;
                        state_next_s = HOLD;
                    end
                end
                DECAY: begin
                    if (raw_s >= level_r) begin
                        level_next_s = raw_s;
                        hold_next_s  = 4'd0;
                        state_next_s = HOLD;
                    end else if (level_r == 5'd1) begin
                        // raw < level guarantees level >= 1, so this never wraps.
                        level_next_s = 5'd0;
                        hold_next_s  = 4'd0;
                        state_next_s = HOLD;
                    end else begin
                        level_next_s = level_r - 5'd1;
                        hold_next_s  = hold_cnt_r;
                        state_next_s = DECAY;
                    end
                end
                default: begin
                    level_next_s = 5'd0;
                    hold_next_s  = 4'd0;
                    state_next_s = HOLD;
                end
            endcase
        end else begin
            state_next_s = state_r;
            level_next_s = level_r;
            hold_next_s  = hold_cnt_r;
        end
    end

    // Peak-hold state, pending level and hold counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= HOLD;
            level_r    <= 5'd0;
            hold_cnt_r <= 4'd0;
        end else begin
            state_r    <= state_next_s;
            level_r    <= level_next_s;
            hold_cnt_r <= hold_next_s;
        end
    end

    // Theme accumulation and frame-synchronous commit; commits see pre-update values.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_theme_r <= 2'd0;
            theme_r         <= 2'd0;
            volume_r        <= 5'd0;
            volume_upd_r    <= 1'b0;
        end else begin
            if (theme_btn) begin
                pending_theme_r <= pending_theme_r + 2'd1;
            end else begin
                pending_theme_r <= pending_theme_r;
            end

            if (frame_begin) begin
                theme_r <= pending_theme_r;
                if (!freeze) begin
                    volume_r     <= level_r;
                    volume_upd_r <= (level_r != volume_r);
                end else begin
                    volume_r     <= volume_r;
                    volume_upd_r <= 1'b0;
                end
            end else begin
                theme_r      <= theme_r;
                volume_r     <= volume_r;
                volume_upd_r <= 1'b0;
            end
        end
    end

    assign volume     = volume_r;
    assign theme_sw   = theme_r;
    assign volume_upd = volume_upd_r;

endmodule

// File: tb/tb_mic_volume_ctrl.sv
// Self-checking bench for mic_volume_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a window/queue based reference model.
module tb_mic_volume_ctrl;

    localparam int W = 8;
    localparam int H = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        sample_valid;
    logic [11:0] sample;
    logic        frame_begin;
    logic        theme_btn;
    logic        freeze;
    logic [4:0]  volume;
    logic [1:0]  theme_sw;
    logic        volume_upd;

    mic_volume_ctrl #(
        .WINDOW_SAMPLES (W),
        .HOLD_WINDOWS   (H),
        .MIDPOINT       (2048),
        .LEVEL_SHIFT    (6),
        .MAX_LEVEL      (15)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample       (sample),
        .frame_begin  (frame_begin),
        .theme_btn    (theme_btn),
        .freeze       (freeze),
        .volume       (volume),
        .theme_sw     (theme_sw),
        .volume_upd   (volume_upd)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: amplitudes of the open window, pending level, quiet-window run.
    int q[$];
    int m_lvl = 0, m_quiet = 0, m_ptheme = 0;
    int m_vol = 0, m_theme = 0, m_upd = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic int amp_of(input int s);
        int a;
        a = (s >= 2048) ? s - 2048 : 2048 - s;
        return (a > 2047) ? 2047 : a;
    endfunction

    task automatic model_edge();
        int pk;
        int lv;
        if (reset) begin
            q.delete();
            m_lvl = 0; m_quiet = 0; m_ptheme = 0;
            m_vol = 0; m_theme = 0; m_upd = 0;
        end else begin
            m_upd = 0;
            if (frame_begin) begin
                m_theme = m_ptheme;
                if (!freeze) begin
                    m_upd = (m_lvl != m_vol) ? 1 : 0;
                    m_vol = m_lvl;
                end
            end
            if (theme_btn) m_ptheme = (m_ptheme + 1) % 4;
            if (sample_valid) begin
                q.push_back(amp_of(int'(sample)));
                if (q.size() == W) begin
                    pk = 0;
                    foreach (q[i]) if (q[i] > pk) pk = q[i];
                    lv = pk / 64;
                    if (lv > 15) lv = 15;
                    if (lv >= m_lvl) begin
                        m_lvl = lv;
                        m_quiet = 0;
                    end else begin
                        m_quiet++;
                        if (m_quiet >= H) m_lvl = m_lvl - 1;
                    end
                    q.delete();
                end
            end
        end
    endtask

    task automatic cyc(input logic r, input logic sv, input int s, input logic fb, input logic btn);
        reset        = r;
        sample_valid = sv;
        sample       = 12'(s);
        frame_begin  = fb;
        theme_btn    = btn;
        @(posedge clk);
        model_edge();
        #1;
        chk("volume", volume, m_vol);
        chk("theme_sw", theme_sw, m_theme);
        chk("volume_upd", volume_upd, m_upd);
    endtask

    task automatic frame();
        cyc(1'b0, 1'b0, 2048, 1'b1, 1'b0);
    endtask

    task automatic win4(input int a, input int b, input int c, input int d);
        int v[4];
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        for (int i = 0; i < W; i++) cyc(1'b0, 1'b1, v[i % 4], 1'b0, 1'b0);
    endtask

    initial begin
        freeze = 1'b0;
        // Reset, with a sample strobe that must be ignored.
        cyc(1'b1, 1'b0, 2048, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 4095, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 2048, 1'b0, 1'b0);
        frame();
        chk("rst_volume", volume, 0);
        chk("rst_theme", theme_sw, 0);
        chk("rst_upd", volume_upd, 0);

        // Peak 952 -> level 14.
        win4(2048, 3000, 1100, 2100);
        frame();
        chk("vol14", volume, 14);
        chk("vol14_upd", volume_upd, 1);
        cyc(1'b0, 1'b0, 2048, 1'b0, 1'b0);
        chk("upd_one_cycle", volume_upd, 0);

        // Silence: held for three windows, then one step per window down to 0.
        for (int k = 0; k < 19; k++) begin
            win4(2048, 2048, 2048, 2048);
            frame();
        end
        chk("decayed_to_0", volume, 0);

        // Recover from DECAY at level 5, then full-scale saturation.
        win4(3000, 3000, 3000, 3000);
        frame();
        for (int k = 0; k < 30; k++) begin
            if (m_lvl == 5) break;
            win4(2048, 2048, 2048, 2048);
            frame();
        end
        chk("at_level5", volume, 5);
        win4(3008, 2048, 2048, 2048);
        frame();
        chk("recover15", volume, 15);
        win4(4095, 0, 2048, 2048);
        frame();
        chk("saturate15", volume, 15);

        // Freeze across loud windows, then release.
        for (int k = 0; k < 25; k++) begin
            win4(2048, 2048, 2048, 2048);
            frame();
        end
        freeze = 1'b1;
        for (int k = 0; k < 3; k++) begin
            win4(3000, 2048, 2048, 2048);
            frame();
            chk("frozen_vol", volume, 0);
            chk("frozen_upd", volume_upd, 0);
        end
        freeze = 1'b0;
        frame();
        chk("unfrozen_vol", volume, 14);
        chk("unfrozen_upd", volume_upd, 1);

        // Theme wrap and press coincident with a frame.
        for (int k = 0; k < 5; k++) cyc(1'b0, 1'b0, 2048, 1'b0, 1'b1);
        frame();
        chk("theme_wrap", theme_sw, 1);
        cyc(1'b0, 1'b0, 2048, 1'b1, 1'b1);
        chk("theme_coinc", theme_sw, 1);
        frame();
        chk("theme_next", theme_sw, 2);

        // Window end coincident with frame start commits the old level.
        for (int k = 0; k < W - 1; k++) cyc(1'b0, 1'b1, 4095, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 4095, 1'b1, 1'b0);
        chk("coinc_old", volume, 14);
        frame();
        chk("coinc_new", volume, 15);

        // Reset mid-window discards the partial peak.
        for (int k = 0; k < 4; k++) cyc(1'b0, 1'b1, 4095, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 4095, 1'b0, 1'b0);
        win4(2100, 2100, 2100, 2100);
        frame();
        chk("post_reset_vol", volume, 0);

        // Random traffic.
        for (int k = 0; k < 3000; k++) begin
            int s;
            if ($urandom_range(0, 63) == 0) freeze = ~freeze;
            if ($urandom_range(0, 1) == 1) s = int'($urandom_range(0, 4095));
            else s = 2048 + int'($urandom_range(0, 800)) - 400;
            cyc(($urandom_range(0, 399) == 0), ($urandom_range(0, 2) != 0), s,
                ($urandom_range(0, 11) == 0), ($urandom_range(0, 15) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
